// File: rtl/dm_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
package dm_responder_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_DEPTH  = 1024;
    localparam int unsigned DEF_WAIT   = 2;
    localparam int unsigned CNT_W      = 4;

    // Request sequencing states
    typedef enum logic [1:0] {
        DM_IDLE   = 2'd0,
        DM_WAIT   = 2'd1,
        DM_ACCESS = 2'd2,
        DM_RESP   = 2'd3
    } dm_state_e;

    // Latched operation; OP_BAD marks read and write requested together
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_BAD   = 2'd3
    } dm_op_e;

    // Operands captured at request time
    typedef struct packed {
        dm_op_e              op;
        logic                legal;
        logic [DATA_W-1:0]   data;
    } dm_req_t;

endpackage

// File: rtl/dm_responder_if.sv
// Controller <-> data-memory request/response bus.
interface dm_responder_if
    import dm_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic                DM_enable;
    logic                DM_read;
    logic                DM_write;
    logic [ADDR_W-1:0]   DM_address;
    logic [DATA_W-1:0]   DM_in;
    logic [DATA_W-1:0]   DM_out;
    logic                DM_ready;
    logic                DM_error;
    logic                DM_busy;

    modport master (
        output DM_enable, DM_read, DM_write, DM_address, DM_in,
        input  DM_out, DM_ready, DM_error, DM_busy
    );

    modport slave (
        input  DM_enable, DM_read, DM_write, DM_address, DM_in,
        output DM_out, DM_ready, DM_error, DM_busy
    );

endinterface

// File: rtl/dm_responder_storage.sv
// Single-port synchronous word RAM; contents are never reset.
module dm_responder_storage
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEF_DEPTH)
) (
    input  logic                clock,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write when enabled; read port always returns the addressed word one cycle later
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: captures one request, waits, accesses storage, pulses ready.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT
) (
    input  logic            clock,
    input  logic            reset,
    dm_responder_if.slave   bus
);

    localparam int unsigned WI_W  = ADDR_W - 2;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    dm_state_e          state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    dm_req_t            req, req_n;
    logic [WI_W-1:0]    idx, idx_n;
    logic [DATA_W-1:0]  out_q, out_n;
    logic               ready_q, ready_n;
    logic               error_q, error_n;
    logic               busy_q, busy_n;

    logic [WI_W-1:0]    in_idx_c;
    logic               in_legal_c;
    logic               ram_we_c;
    logic [DATA_W-1:0]  ram_dout;

    // Legality of the request currently on the bus
    always_comb begin
        in_idx_c   = bus.DM_address[ADDR_W-1:2];
        in_legal_c = !(bus.DM_read && bus.DM_write)
                     && (bus.DM_address[1:0] == 2'b00)
                     && (32'(in_idx_c) < DEPTH);
    end

    // Storage is touched only in ACCESS and only for a legal write
    assign ram_we_c = (state == DM_ACCESS) && req.legal && (req.op == OP_WRITE);

    dm_responder_storage #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_storage (
        .clock (clock),
        .we    (ram_we_c),
        .addr  (IDX_W'(idx)),
        .din   (req.data),
        .dout  (ram_dout)
    );

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = req;
        idx_n   = idx;
        out_n   = out_q;
        ready_n = 1'b0;
        error_n = 1'b0;
        busy_n  = 1'b0;
        case (state)
            DM_IDLE: begin
                if (bus.DM_enable && (bus.DM_read || bus.DM_write)) begin
                    req_n.op    = (bus.DM_read && bus.DM_write) ? OP_BAD :
                                  (bus.DM_read ? OP_READ : OP_WRITE);
                    req_n.legal = in_legal_c;
                    req_n.data  = bus.DM_in;
                    idx_n       = in_idx_c;
                    cnt_n       = CNT_W'(WAIT_CYCLES);
                    state_n     = (WAIT_CYCLES != 0) ? DM_WAIT : DM_ACCESS;
                end
            end
            DM_WAIT: begin
                busy_n = 1'b1;
                cnt_n  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = DM_ACCESS;
                end
            end
            DM_ACCESS: begin
                busy_n  = 1'b1;
                state_n = DM_RESP;
            end
            DM_RESP: begin
                // Response registers update here so ready shows in the next (idle) cycle
                state_n = DM_IDLE;
                ready_n = 1'b1;
                error_n = !req.legal;
                if (req.legal && (req.op == OP_READ)) begin
                    out_n = ram_dout;
                end
            end
            default: state_n = DM_IDLE;
        endcase
    end

    // State, request latches and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= DM_IDLE;
            cnt     <= '0;
            req     <= '0;
            idx     <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            req     <= req_n;
            idx     <= idx_n;
            out_q   <= out_n;
            ready_q <= ready_n;
            error_q <= error_n;
            busy_q  <= busy_n;
        end
    end

    assign bus.DM_out   = out_q;
    assign bus.DM_ready = ready_q;
    assign bus.DM_error = error_q;
    assign bus.DM_busy  = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: two instances (2 wait states / 1000 words, 0 wait states / 1024 words)
// checked every cycle against a latency-level model, plus directed literal expectations.
module tb_dm_responder;
    import dm_responder_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned W0 = 2;
    localparam int unsigned D0 = 1000;
    localparam int unsigned W1 = 0;
    localparam int unsigned D1 = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dm_responder_if #(.ADDR_W(AW)) bus0 ();
    dm_responder_if #(.ADDR_W(AW)) bus1 ();

    dm_responder #(.ADDR_W(AW), .DEPTH(D0), .WAIT_CYCLES(W0)) dut0 (
        .clock (clock), .reset (reset), .bus (bus0)
    );
    dm_responder #(.ADDR_W(AW), .DEPTH(D1), .WAIT_CYCLES(W1)) dut1 (
        .clock (clock), .reset (reset), .bus (bus1)
    );

    logic          en  [2];
    logic          rd  [2];
    logic          wr  [2];
    logic [AW-1:0] ad  [2];
    logic [31:0]   din [2];
    logic [31:0]   dout [2];
    logic          rdy [2];
    logic          err [2];
    logic          bsy [2];

    assign bus0.DM_enable = en[0];  assign bus1.DM_enable = en[1];
    assign bus0.DM_read   = rd[0];  assign bus1.DM_read   = rd[1];
    assign bus0.DM_write  = wr[0];  assign bus1.DM_write  = wr[1];
    assign bus0.DM_address = ad[0]; assign bus1.DM_address = ad[1];
    assign bus0.DM_in     = din[0]; assign bus1.DM_in     = din[1];
    assign dout[0] = bus0.DM_out;   assign dout[1] = bus1.DM_out;
    assign rdy[0]  = bus0.DM_ready; assign rdy[1]  = bus1.DM_ready;
    assign err[0]  = bus0.DM_error; assign err[1]  = bus1.DM_error;
    assign bsy[0]  = bus0.DM_busy;  assign bsy[1]  = bus1.DM_busy;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, k, $time, act, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? int'(W0) : int'(W1);
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? int'(D0) : int'(D1);
    endfunction

    // Behavioural model: a request accepted at edge N writes/reads memory at edge N+W+1,
    // shows ready/error/data after edge N+W+2, busy after edges N+1..N+W+1, and the next
    // request can be accepted from edge N+W+3 on.
    logic [31:0] mem_m   [2][1024];
    bit          known_m [2][1024];
    bit          pend    [2];
    bit          p_rd    [2];
    bit          p_wr    [2];
    bit          p_legal [2];
    int          p_idx   [2];
    logic [31:0] p_data  [2];
    logic [31:0] p_rdata [2];
    bit          p_rknown[2];
    int          cap_e   [2];
    int          free_e  [2];
    int          cyc = 0;
    logic [31:0] e_out   [2];
    bit          e_known [2];
    bit          e_rdy   [2];
    bit          e_err   [2];
    bit          e_bsy   [2];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                pend[k]    = 1'b0;
                free_e[k]  = 0;
                e_out[k]   = 32'h0;
                e_known[k] = 1'b1;
                e_rdy[k]   = 1'b0;
                e_err[k]   = 1'b0;
                e_bsy[k]   = 1'b0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                int w;
                w = wait_of(k);
                e_rdy[k] = 1'b0;
                e_err[k] = 1'b0;
                if (pend[k] && cyc == cap_e[k] + w + 1 && p_legal[k]) begin
                    if (p_wr[k]) begin
                        mem_m[k][p_idx[k]]   = p_data[k];
                        known_m[k][p_idx[k]] = 1'b1;
                    end else begin
                        p_rdata[k]  = mem_m[k][p_idx[k]];
                        p_rknown[k] = known_m[k][p_idx[k]];
                    end
                end
                if (pend[k] && cyc == cap_e[k] + w + 2) begin
                    e_rdy[k] = 1'b1;
                    e_err[k] = !p_legal[k];
                    if (p_legal[k] && p_rd[k]) begin
                        e_out[k]   = p_rdata[k];
                        e_known[k] = p_rknown[k];
                    end
                    pend[k] = 1'b0;
                end
                e_bsy[k] = pend[k] && (cyc >= cap_e[k] + 1) && (cyc <= cap_e[k] + w + 1);
                if (!pend[k] && cyc >= free_e[k] && en[k] && (rd[k] || wr[k])) begin
                    p_rd[k]    = rd[k];
                    p_wr[k]    = wr[k];
                    p_idx[k]   = int'(ad[k][AW-1:2]);
                    p_legal[k] = !(rd[k] && wr[k]) && (ad[k][1:0] == 2'b00) && (p_idx[k] < depth_of(k));
                    p_data[k]  = din[k];
                    cap_e[k]   = cyc;
                    free_e[k]  = cyc + w + 3;
                    pend[k]    = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            chk("ready", k, 32'(rdy[k]), 32'(e_rdy[k]));
            chk("error", k, 32'(err[k]), 32'(e_err[k]));
            chk("busy",  k, 32'(bsy[k]), 32'(e_bsy[k]));
            if (e_known[k]) chk("out", k, dout[k], e_out[k]);
        end
    end

    task automatic set_req(input int k, input bit r, input bit w, input logic [AW-1:0] a, input logic [31:0] d);
        en[k] = 1'b1; rd[k] = r; wr[k] = w; ad[k] = a; din[k] = d;
    endtask

    task automatic clr_req(input int k);
        en[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
    endtask

    // Counts edges until ready is seen (sampled at negedge) and busy cycles on the way
    task automatic wait_ready(input int k, output int lat, output int nb);
        bit got;
        got = 1'b0; lat = 0; nb = 0;
        while (!got && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (bsy[k]) nb++;
            if (rdy[k]) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ready_timeout dut%0d t=%0t got=no ready want=ready within 40 cycles", k, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ready cycle
    task automatic txn(input int k, input bit r, input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                       output int lat, output int nb);
        set_req(k, r, w, a, d);
        @(posedge clock);
        #1;
        clr_req(k);
        wait_ready(k, lat, nb);
    endtask

    initial begin
        int lat;
        int nb;
        for (int k = 0; k < 2; k++) begin
            clr_req(k);
            ad[k]  = '0;
            din[k] = '0;
        end

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_out",   0, dout[0], 32'h0);
        chk("rst_ready", 0, 32'(rdy[0]), 32'h0);
        chk("rst_busy",  1, 32'(bsy[1]), 32'h0);
        reset = 1'b0;

        // Preload a 16-word pool in both instances
        for (int w = 0; w < 16; w++) begin
            txn(0, 1'b0, 1'b1, AW'(w * 4), 32'hC0DE_0000 | 32'(w * 4), lat, nb);
            txn(1, 1'b0, 1'b1, AW'(w * 4), $urandom, lat, nb);
        end

        // Write then read with two wait states
        txn(0, 1'b0, 1'b1, 12'h004, 32'h1234_5678, lat, nb);
        chk("wr_latency", 0, 32'(lat), 32'd4);
        chk("wr_busy_cycles", 0, 32'(nb), 32'd3);
        txn(0, 1'b1, 1'b0, 12'h004, 32'h0, lat, nb);
        chk("rd_latency", 0, 32'(lat), 32'd4);
        chk("rd_data", 0, dout[0], 32'h1234_5678);
        chk("rd_error", 0, 32'(err[0]), 32'h0);

        // Zero wait states
        repeat (2) @(negedge clock);
        txn(1, 1'b1, 1'b0, 12'h008, 32'h0, lat, nb);
        chk("w0_latency", 1, 32'(lat), 32'd2);
        chk("w0_busy_cycles", 1, 32'(nb), 32'd1);

        // Illegal requests leave storage and DM_out untouched
        txn(0, 1'b0, 1'b1, 12'h006, 32'hBAD0_0006, lat, nb);
        chk("misalign_err", 0, 32'(err[0]), 32'h1);
        chk("misalign_out", 0, dout[0], 32'h1234_5678);
        txn(0, 1'b0, 1'b1, AW'(D0 * 4), 32'hBAD0_0FA0, lat, nb);
        chk("range_err", 0, 32'(err[0]), 32'h1);
        txn(0, 1'b1, 1'b1, 12'h004, 32'hBAD0_0004, lat, nb);
        chk("rdwr_err", 0, 32'(err[0]), 32'h1);
        chk("rdwr_out", 0, dout[0], 32'h1234_5678);
        txn(0, 1'b1, 1'b0, 12'h004, 32'h0, lat, nb);
        chk("after_illegal", 0, dout[0], 32'h1234_5678);
        txn(0, 1'b1, 1'b0, 12'h000, 32'h0, lat, nb);
        chk("range_no_alias", 0, dout[0], 32'hC0DE_0000);

        // Request while busy is dropped
        set_req(0, 1'b1, 1'b0, 12'h000, 32'h0);
        @(posedge clock); #1; clr_req(0);
        @(posedge clock); #1;
        set_req(0, 1'b0, 1'b1, 12'h00C, 32'hBAD0_000C);
        @(negedge clock);
        chk("drop_busy", 0, 32'(bsy[0]), 32'h1);
        @(posedge clock); #1; clr_req(0);
        wait_ready(0, lat, nb);
        txn(0, 1'b1, 1'b0, 12'h00C, 32'h0, lat, nb);
        chk("drop_data", 0, dout[0], 32'hC0DE_000C);

        // Back-to-back write then read of the same word
        txn(0, 1'b0, 1'b1, 12'h020, 32'h0000_00AA, lat, nb);
        txn(0, 1'b1, 1'b0, 12'h020, 32'h0, lat, nb);
        chk("b2b_latency", 0, 32'(lat), 32'd4);
        chk("b2b_data", 0, dout[0], 32'h0000_00AA);

        // Reset in the middle of a write aborts it
        set_req(0, 1'b0, 1'b1, 12'h010, 32'hDEAD_BEEF);
        @(posedge clock); #1; clr_req(0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_out",   0, dout[0], 32'h0);
        chk("midrst_busy",  0, 32'(bsy[0]), 32'h0);
        chk("midrst_ready", 0, 32'(rdy[0]), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        txn(0, 1'b1, 1'b0, 12'h010, 32'h0, lat, nb);
        chk("midrst_keep", 0, dout[0], 32'hC0DE_0010);

        // Randomized traffic, including requests issued while busy
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int op;
                    int sel;
                    logic [AW-1:0] a;
                    op  = int'($urandom_range(0, 9));
                    sel = int'($urandom_range(0, 9));
                    a   = AW'($urandom_range(0, 15) * 4);
                    if (sel == 8 || (sel == 9 && k == 1)) a = a | AW'($urandom_range(1, 3));
                    else if (sel == 9) a = AW'(D0 * 4 + 4 * $urandom_range(0, 23));
                    set_req(k, (op <= 3) || (op == 8), (op >= 4 && op <= 8), a, $urandom);
                end else begin
                    clr_req(k);
                end
            end
        end
        for (int k = 0; k < 2; k++) clr_req(k);
        repeat (20) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
